button_events: RTL and testbench

Downstream stage of the button/switch debouncer. It takes the clean, debounced level and turns it into single-cycle event pulses: press, release, long-press and auto-repeat. It also provides a registered "held" level. Its consumers are the control/CSR logic, which need events rather than levels.

---
 rtl/btn_pkg.sv | 29 ++
 rtl/ms_tick_gen.sv | 50 +++++
 rtl/button_events.sv | 154 +++++++++++++++
 tb/tb_button_events.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button event blocks.
//   btn_state_t   : FSM state encoding for button_events
//   cycles_per_ms : clock cycles in one millisecond for a clock of FREQ MHz
//   max_u         : larger of two unsigned values
//   cnt_width     : bits needed to hold 0..max_val (at least 1)
`timescale 1ns / 1ps
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int unsigned MinCntWidth = 1;

  function automatic int unsigned cycles_per_ms(input int unsigned freq);
    return freq * 1000;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? MinCntWidth : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator.
// A prescaler counts 0..FREQ*1000-1 and o_tick is high for the one cycle the
// count sits at its terminal value. i_clr restarts the count from zero, so the
// first tick after a clear lands exactly FREQ*1000 cycles after the clear cycle.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous reset, active-low
//   i_clr  : synchronous restart of the prescaler
//   o_tick : one-cycle pulse once per millisecond
`timescale 1ns / 1ps
module ms_tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned FREQ = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned Cycles = cycles_per_ms(FREQ);
  localparam int unsigned Width  = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [Width-1:0] LastCnt = Width'(Cycles - 1);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             terminal;

  assign terminal = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clr || terminal) begin
      cnt_d = '0;
    end
  end

  // A clear in the terminal cycle swallows that tick so a restart never
  // produces an early pulse.
  assign o_tick = terminal & ~i_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_events.sv
// Button event generator: turns a debounced level into one-cycle event pulses.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous reset, active-low
//   i_btn     : debounced button level, active-high, already synchronous to clk
//   i_en      : block enable; low forces IDLE and suppresses all events
//   o_press   : pulse one cycle after a press
//   o_release : pulse one cycle after a release (only from PRESSED or LONG)
//   o_long    : pulse when the hold reaches LONG_MS
//   o_repeat  : pulse every REPEAT_MS after o_long while still held (0 disables)
//   o_held    : high while the FSM is PRESSED or LONG
// All outputs are registered: an event detected in cycle N shows in cycle N+1.
`timescale 1ns / 1ps
module button_events
  import btn_pkg::*;
#(
  parameter int unsigned FREQ      = 25,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_en,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int unsigned CntMax = max_u(LONG_MS, REPEAT_MS);
  localparam int unsigned CntW   = cnt_width(CntMax);

  localparam logic [CntW-1:0] LongLast = CntW'(LONG_MS - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'((REPEAT_MS == 0) ? 32'd0 : REPEAT_MS - 1);
  localparam logic [CntW-1:0] CntSat   = '1;
  localparam logic            RepOn    = (REPEAT_MS != 0);

  btn_state_t      state_q, state_d;
  logic [CntW-1:0] ms_cnt_q, ms_cnt_d;
  logic            btn_q;
  logic            rise, fall;
  logic            ms_tick, tick_clr;
  logic            reload;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;
  logic            held_q, held_d;

  assign rise = i_btn & ~btn_q;
  assign fall = ~i_btn & btn_q;

  // Restarting the prescaler on rise aligns every ms boundary to the press.
  assign tick_clr = rise | ~i_en;

  ms_tick_gen #(
    .FREQ(FREQ)
  ) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (tick_clr),
    .o_tick(ms_tick)
  );

  // Next-state and event decode. Fall is checked first so a release in the
  // same cycle as a long/repeat condition reports only the release.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    reload    = 1'b0;
    if (!i_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESSED;
            press_d = 1'b1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_d   = IDLE;
            release_d = 1'b1;
          end else if (ms_tick && (ms_cnt_q == LongLast)) begin
            state_d = LONG;
            long_d  = 1'b1;
            reload  = 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            state_d   = IDLE;
            release_d = 1'b1;
          end else if (RepOn && ms_tick && (ms_cnt_q == RepLast)) begin
            repeat_d = 1'b1;
            reload   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Millisecond counter: restarts on press, reload or disable; saturates.
  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if (rise || !i_en || reload) begin
      ms_cnt_d = '0;
    end else if (ms_tick && (ms_cnt_q != CntSat)) begin
      ms_cnt_d = ms_cnt_q + 1'b1;
    end
  end

  assign held_d = (state_d != IDLE);

  // btn_q tracks the input even while disabled so re-enabling with the button
  // already down does not look like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      btn_q     <= 1'b0;
      ms_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= i_btn;
      ms_cnt_q  <= ms_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = held_q;

endmodule

// File: tb/tb_button_events.sv
// Two instances share stimulus: dut_a repeats every 2 ms, dut_b has repeat off.
// Expected output vectors come from a timing model based on elapsed cycles since
// the press; the driver queues them and a monitor pops and compares each cycle.
`timescale 1ns / 1ps
module tb_button_events;

  localparam int unsigned Freq  = 1;
  localparam int unsigned LongMs = 3;
  localparam int unsigned RepMs = 2;
  localparam longint     Cpm   = longint'(Freq) * 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic i_btn;
  logic i_en;
  logic a_press, a_release, a_long, a_repeat, a_held;
  logic b_press, b_release, b_long, b_repeat, b_held;

  always #5 clk = ~clk;

  button_events #(
    .FREQ(Freq), .LONG_MS(LongMs), .REPEAT_MS(RepMs)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_en(i_en),
    .o_press(a_press), .o_release(a_release), .o_long(a_long),
    .o_repeat(a_repeat), .o_held(a_held)
  );

  button_events #(
    .FREQ(Freq), .LONG_MS(LongMs), .REPEAT_MS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_en(i_en),
    .o_press(b_press), .o_release(b_release), .o_long(b_long),
    .o_repeat(b_repeat), .o_held(b_held)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [9:0] exp_q[$];
  longint     cyc = 0;

  // Reference model state: last sampled level, and per instance whether a
  // press is being tracked and the cycle it started.
  logic   m_prev = 1'b0;
  logic   m_active[2];
  longint m_start[2];

  // Event counts seen on the DUT outputs (written by the monitor only).
  int unsigned ev_press[2], ev_rel[2], ev_long[2], ev_rep[2];
  int unsigned s_press[2], s_rel[2], s_long[2], s_rep[2];

  // Returns {press, release, long, repeat, held} expected one cycle later.
  function automatic logic [4:0] model(input int idx, input int unsigned rep,
                                       input logic b, input logic e);
    logic       rise, fall;
    longint     el, lc, rc;
    logic [4:0] o;
    rise = b & ~m_prev;
    fall = ~b & m_prev;
    o    = '0;
    lc   = longint'(LongMs) * Cpm;
    rc   = longint'(rep) * Cpm;
    if (!e) begin
      m_active[idx] = 1'b0;
    end else if (m_active[idx]) begin
      el = cyc - m_start[idx];
      if (fall) begin
        o[3] = 1'b1;
        m_active[idx] = 1'b0;
      end else if (el == lc) begin
        o[2] = 1'b1;
      end else if (rep != 0 && el > lc && ((el - lc) % rc) == 0) begin
        o[1] = 1'b1;
      end
    end else if (rise) begin
      o[4] = 1'b1;
      m_active[idx] = 1'b1;
      m_start[idx]  = cyc;
    end
    o[0] = m_active[idx];
    return o;
  endfunction

  task automatic step(input logic b, input logic e, input logic r);
    logic       was;
    logic [4:0] ea, eb;
    @(negedge clk);
    was   = rst_n;
    rst_n = r;
    i_btn = b;
    i_en  = e;
    if (!r) begin
      m_prev = 1'b0;
      for (int k = 0; k < 2; k++) m_active[k] = 1'b0;
      ea = '0;
      eb = '0;
    end else begin
      ea = model(0, RepMs, b, e);
      eb = model(1, 0, b, e);
      m_prev = b;
    end
    exp_q.push_back({ea, eb});
    cyc++;
    if (was && !r) begin
      #1;
      n_checks++;
      if ({a_press, a_release, a_long, a_repeat, a_held,
           b_press, b_release, b_long, b_repeat, b_held} !== 10'b0) begin
        n_errors++;
        $display("FAIL reset_immediate: outputs %b%b%b%b%b %b%b%b%b%b, required all 0",
                 a_press, a_release, a_long, a_repeat, a_held,
                 b_press, b_release, b_long, b_repeat, b_held);
      end
    end
  endtask

  task automatic hold(input logic b, input logic e, input int n);
    for (int k = 0; k < n; k++) step(b, e, 1'b1);
  endtask

  task automatic snap();
    for (int k = 0; k < 2; k++) begin
      s_press[k] = ev_press[k];
      s_rel[k]   = ev_rel[k];
      s_long[k]  = ev_long[k];
      s_rep[k]   = ev_rep[k];
    end
  endtask

  task automatic expect_count(input string name, input int unsigned got,
                              input int unsigned want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: counted %0d, required %0d", name, got, want);
    end
  endtask

  // Checks pulse counts since the last snap(); idle a few cycles first so the
  // monitor has caught up.
  task automatic expect_events(input string name, input int idx, input int unsigned p,
                               input int unsigned rl, input int unsigned lg,
                               input int unsigned rp);
    expect_count({name, ".press"},   ev_press[idx] - s_press[idx], p);
    expect_count({name, ".release"}, ev_rel[idx] - s_rel[idx], rl);
    expect_count({name, ".long"},    ev_long[idx] - s_long[idx], lg);
    expect_count({name, ".repeat"},  ev_rep[idx] - s_rep[idx], rp);
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector just after the
  // clock edge; compare it with the oldest queued expectation.
  initial begin
    logic [9:0] e;
    logic [4:0] ga, gb;
    for (int k = 0; k < 2; k++) begin
      ev_press[k] = 0; ev_rel[k] = 0; ev_long[k] = 0; ev_rep[k] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ga = {a_press, a_release, a_long, a_repeat, a_held};
        gb = {b_press, b_release, b_long, b_repeat, b_held};
        n_checks++;
        if (ga !== e[9:5]) begin
          n_errors++;
          $display("FAIL dut_a t=%0t: outputs prlRh=%b, required %b", $time, ga, e[9:5]);
        end
        n_checks++;
        if (gb !== e[4:0]) begin
          n_errors++;
          $display("FAIL dut_b t=%0t: outputs prlRh=%b, required %b", $time, gb, e[4:0]);
        end
        ev_press[0] += ga[4]; ev_rel[0] += ga[3]; ev_long[0] += ga[2]; ev_rep[0] += ga[1];
        ev_press[1] += gb[4]; ev_rel[1] += gb[3]; ev_long[1] += gb[2]; ev_rep[1] += gb[1];
      end
    end
  end

  initial begin
    int unsigned dur;
    logic        lvl;
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_start[k]  = 0;
    end
    rst_n = 1'b1;
    i_btn = 1'b0;
    i_en  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    hold(1'b0, 1'b1, 20);

    // 1. Short press.
    snap();
    hold(1'b1, 1'b1, 1000);
    hold(1'b0, 1'b1, 20);
    expect_events("short_a", 0, 1, 1, 0, 0);

    // 2. Long press with repeat; fall lands on a repeat boundary.
    snap();
    hold(1'b1, 1'b1, 9000);
    hold(1'b0, 1'b1, 20);
    expect_events("longrep_a", 0, 1, 1, 1, 2);
    expect_events("longrep_b", 1, 1, 1, 1, 0);

    // 3. Release in the cycle the long condition triggers.
    snap();
    hold(1'b1, 1'b1, 3000);
    hold(1'b0, 1'b1, 20);
    expect_events("longedge_a", 0, 1, 1, 0, 0);

    // 4. Enable gating while held, then release and press again.
    snap();
    hold(1'b1, 1'b1, 1500);
    hold(1'b1, 1'b0, 100);
    hold(1'b1, 1'b1, 200);
    hold(1'b0, 1'b1, 20);
    hold(1'b1, 1'b1, 50);
    hold(1'b0, 1'b1, 20);
    expect_events("enable_a", 0, 2, 1, 0, 0);

    // 5. Async reset mid-hold with the button still down.
    snap();
    hold(1'b1, 1'b1, 2000);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    hold(1'b1, 1'b1, 3500);
    hold(1'b0, 1'b1, 20);
    expect_events("reset_a", 0, 2, 1, 1, 0);

    // 6. Repeat disabled on dut_b; dut_a repeats at 5000/7000/9000.
    snap();
    hold(1'b1, 1'b1, 10000);
    hold(1'b0, 1'b1, 20);
    expect_events("norep_b", 1, 1, 1, 1, 0);
    expect_events("norep_a", 0, 1, 1, 1, 3);

    // Random phase: mixed short/long holds, enable drops and resets.
    lvl = 1'b0;
    for (int s = 0; s < 24; s++) begin
      lvl = ~lvl;
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(2990, 7200) : $urandom_range(1, 400);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) step(lvl, 1'b1, 1'b0);
      end
      if ($urandom_range(0, 5) == 0) begin
        hold(lvl, 1'b1, int'(dur / 2));
        hold(lvl, 1'b0, int'($urandom_range(1, 60)));
        hold(lvl, 1'b1, int'(dur / 2));
      end else begin
        hold(lvl, 1'b1, int'(dur));
      end
    end
    hold(1'b0, 1'b1, 10);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
